// File: rtl/led_sched_pkg.sv
// Shared types and constants for the board LED/button controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package led_sched_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_SW     = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam logic [LED_W-1:0] SEED_SHIFT  = 4'b0001;
    localparam logic [LED_W-1:0] SEED_COUNT  = 4'b0000;
    localparam logic [LED_W-1:0] SEED_BOUNCE = 4'b0001;

    // Press order; BOUNCE only sits in the cycle when LED_SCHED_BOUNCE_EN is defined.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        n = MODE_SW;
        case (m)
            MODE_SW:    n = MODE_SHIFT;
            MODE_SHIFT: n = MODE_COUNT;
`ifdef LED_SCHED_BOUNCE_EN
            MODE_COUNT: n = MODE_BOUNCE;
`endif
            default:    n = MODE_SW;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces an active-low push-button into a single press pulse.
// Latency: press_evt combinational in the cycle before btn_pulse; btn_pulse 1+DEBOUNCE_CYCLES edges after first sample.
// Backpressure: none; pulse is fire-and-forget, release edges produce nothing.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press_evt,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic          pressed;
    logic          state;
    logic [CW-1:0] cnt;
    logic          flip;

    assign pressed   = ~sync[1];
    assign flip      = (pressed != state) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press_evt = flip && !state;

    // Synchronizer resets to the released level so reset does not look like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= 2'b11;
            state     <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_n};
            btn_pulse <= press_evt;
            if (pressed == state) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_scheduler.sv
// Owns the board LEDs: Nios pass-through or a timer-stepped local pattern, mode advanced by button presses.
// Latency: sw_leds->leds 1 cycle; mode/seed change on the btn_pulse edge; steps every STEP_CYCLES. Macro: LED_SCHED_BOUNCE_EN.
// Backpressure: none; every input is sampled every cycle.
module led_scheduler
    import led_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 12_500_000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             btn_n,
    input  logic [LED_W-1:0] sw_leds,
    output logic [LED_W-1:0] leds,
    output logic             btn_pulse,
    output logic [1:0]       mode
);

    localparam int TW = $clog2(STEP_CYCLES);

    logic          press_evt;
    logic [TW-1:0] timer;
    logic          tick;
    mode_t         mode_q;
    mode_t         mode_nxt;
`ifdef LED_SCHED_BOUNCE_EN
    logic          dir_up;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .btn_n     (btn_n),
        .press_evt (press_evt),
        .btn_pulse (btn_pulse)
    );

    assign tick     = (timer == TW'(STEP_CYCLES - 1));
    assign mode_nxt = next_mode(mode_q);
    assign mode     = mode_q;

    // leds doubles as the pattern register; in MODE_SW it just tracks sw_leds.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mode_q <= MODE_SW;
            timer  <= '0;
            leds   <= '0;
`ifdef LED_SCHED_BOUNCE_EN
            dir_up <= 1'b1;
`endif
        end else if (press_evt) begin
            // A press on a tick edge wins: the tick is dropped and the seed loads.
            mode_q <= mode_nxt;
            timer  <= '0;
            case (mode_nxt)
                MODE_SHIFT: leds <= SEED_SHIFT;
                MODE_COUNT: leds <= SEED_COUNT;
`ifdef LED_SCHED_BOUNCE_EN
                MODE_BOUNCE: begin
                    leds   <= SEED_BOUNCE;
                    dir_up <= 1'b1;
                end
`endif
                default:    leds <= sw_leds;
            endcase
        end else begin
            timer <= tick ? '0 : timer + TW'(1);
            case (mode_q)
                MODE_SHIFT: if (tick) leds <= {leds[LED_W-2:0], leds[LED_W-1]};
                MODE_COUNT: if (tick) leds <= leds + LED_W'(1);
`ifdef LED_SCHED_BOUNCE_EN
                MODE_BOUNCE: if (tick) begin
                    if (dir_up) begin
                        if (leds[LED_W-1]) begin
                            dir_up <= 1'b0;
                            leds   <= leds >> 1;
                        end else begin
                            leds <= leds << 1;
                        end
                    end else begin
                        if (leds[0]) begin
                            dir_up <= 1'b1;
                            leds   <= leds << 1;
                        end else begin
                            leds <= leds >> 1;
                        end
                    end
                end
`endif
                default:    leds <= sw_leds;
            endcase
        end
    end

endmodule
